ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage of the RISC-V core. Holds the program counter, drives the word-addressed instruction ROM with it, and registers the returned 32-bit word plus its PC into a valid/ready output toward decode. It accepts PC redirects from execute (branches, jumps, traps) and stops fetching on a misaligned PC until redirected.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  32  byte address to the instruction ROM; equals current PC combinationally.
- rom_data  in  32  instruction word returned combinationally by the ROM for rom_addr.
- redirect_valid  in  1  load redirect_pc into PC this cycle and flush the output.
- redirect_pc  in  32  new PC target.
- out_valid  out  1  out_inst/out_pc/out_misaligned hold a fetched instruction.
- out_ready  in  1  decode accepts the output this cycle.
- out_inst  out  32  fetched instruction.
- out_pc  out  32  PC of out_inst.
- out_misaligned  out  1  out_pc[1:0] != 0; out_inst is a NOP.
- perf_fetched  out  32  only with IFETCH_PERF_EN.
- perf_stall  out  32  only with IFETCH_PERF_EN.

## Operation
- State: pc (32 bits), output register (valid, inst, pc, misaligned), FSM {RUN, HALT}.
- Reset values: pc = RESET_PC, state = RUN, out_valid = 0, out_inst = 32'h0000_0013, out_pc = 0, out_misaligned = 0, perf counters = 0. rst overrides all other inputs, including redirect_valid.
- Advance condition: adv = !out_valid || out_ready.
- Priority per cycle: rst > redirect_valid > fetch.
- Redirect, any state:
  - pc <= redirect_pc; out_valid <= 0; state <= RUN.
  - Other output fields hold.
  - Does not depend on out_ready. A handshake in the same cycle counts as accepted by decode, and the output still clears.
- RUN and adv with pc[1:0] == 0:
  - out_inst <= rom_data; out_pc <= pc; out_misaligned <= 0; out_valid <= 1.
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- RUN and adv with pc[1:0] != 0:
  - out_inst <= 32'h0000_0013; out_pc <= pc; out_misaligned <= 1; out_valid <= 1.
  - pc holds; state <= HALT.
- RUN and !adv: everything holds (stall). Output fields stay stable while out_valid && !out_ready.
- HALT:
  - No new fetch. pc holds.
  - Pending output drains normally: out_valid <= 0 once accepted.
  - Leaves HALT only by redirect or rst.
- rom_addr = pc in every state. The ROM ignores bits above its depth; ifetch does no range check.

## Timing
- Fetch latency: rom_addr = P in cycle t gives out_valid = 1 with out_pc = P from cycle t+1.
- Throughput: 1 instruction/cycle while out_ready stays 1.
- Redirect asserted in cycle t: out_valid = 0 in cycle t+1; the target instruction is valid in cycle t+2 (one bubble).
- After reset deasserts in cycle t: rom_addr = RESET_PC in cycle t; the first instruction is valid in cycle t+1.
- No combinational path from out_ready or redirect_* to any output.

## Configuration
- IFETCH_PERF_EN defined:
  - perf_fetched increments on every cycle with out_valid && out_ready.
  - perf_stall increments on every cycle with out_valid && !out_ready.
  - Both wrap modulo 2^32 and clear on rst.
- IFETCH_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then free run, ROM word[i] = i, out_ready = 1 → out_pc 0,4,8,… and out_inst 0,1,2,… on consecutive cycles starting 1 cycle after reset release.
- out_ready = 0 for 3 cycles while out_pc = 8 → out_pc = 8 and out_inst stay stable, and rom_addr stays 12. When out_ready returns to 1, out_pc goes 12, 16 on the following cycles. With IFETCH_PERF_EN, perf_stall = 3.
- redirect_valid with redirect_pc = 32'h100 while out_ready = 0 → out_valid = 0 next cycle, then out_pc = 32'h100.
- redirect_pc = 32'h102 → one output with out_misaligned = 1, out_inst = 32'h13, out_pc = 32'h102. Then out_valid = 0 and rom_addr = 32'h102 until the next redirect (to 32'h200), which resumes at 32'h200.
- rst asserted together with redirect_valid mid-stream → outputs at reset values next cycle, rom_addr = RESET_PC. PC 32'hFFFF_FFFC fetch → next out_pc = 0.

Source files
------------

// File: rtl/ifetch_if.sv
// ifetch_if: instruction ROM port, redirect input and decode-facing valid/ready output of the fetch stage.
`default_nettype none

// +----------------------------------------------------------------------+
// | Interface : ifetch_if                                                |
// | Brief     : ROM bus, redirect and fetch->decode handshake bundle     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface ifetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_misaligned;

  // Fetch-stage side
  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_misaligned
  );

  // ROM / execute / decode side
  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/ifetch.sv
// ifetch: RISC-V instruction fetch stage with PC, registered valid/ready output and misaligned-PC halt.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module    : ifetch                                                   |
// | Brief     : PC register, ROM addressing, decode output register      |
// |             Macro IFETCH_PERF_EN adds perf_fetched / perf_stall      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ifetch_if.master   bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_inst;
  logic [31:0] r_out_pc;
  logic        r_out_misaligned;

  logic        w_adv;
  logic        w_pc_aligned;
  logic        w_fetch;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign w_pc_aligned = (r_pc[1:0] == 2'b00);
  assign w_fetch      = (r_state == ST_RUN) && w_adv;

  // Every output comes straight from a register: no path from out_ready or redirect_*.
  assign bus.rom_addr       = r_pc;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_inst       = r_out_inst;
  assign bus.out_pc         = r_out_pc;
  assign bus.out_misaligned = r_out_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_RUN;
      r_pc             <= RESET_PC;
      r_out_valid      <= 1'b0;
      r_out_inst       <= NOP_INST;
      r_out_pc         <= 32'h0000_0000;
      r_out_misaligned <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Flush only clears valid; the stale payload fields are left untouched.
      r_pc        <= bus.redirect_pc;
      r_out_valid <= 1'b0;
      r_state     <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc;
            if (w_pc_aligned) begin
              r_out_inst       <= bus.rom_data;
              r_out_misaligned <= 1'b0;
              r_pc             <= r_pc + PC_STEP;
            end else begin
              // Emit one NOP tagged misaligned, then park until redirected.
              r_out_inst       <= NOP_INST;
              r_out_misaligned <= 1'b1;
              r_state          <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 32'h0000_0000;
      r_perf_stall   <= 32'h0000_0000;
    end else if (r_out_valid) begin
      if (bus.out_ready) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for ifetch; ROM word[i] = i, accepted outputs checked in order.
`default_nettype none

module tb_ifetch;
  logic clk;
  logic rst;

  ifetch_if bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // Word-indexed ROM: word[i] = i
  assign bus.rom_data = {2'b00, bus.rom_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: every accepted output must match the next expected entry.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h with empty scoreboard", bus.out_pc, bus.out_inst);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_inst !== e.inst || bus.out_misaligned !== e.mis) begin
          n_err++;
          $display("FAIL sb_item: got pc=%h inst=%h mis=%b expected pc=%h inst=%h mis=%b",
                   bus.out_pc, bus.out_inst, bus.out_misaligned, e.pc, e.inst, e.mis);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h13 || bus.out_pc !== 32'h0 || bus.out_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: got v=%b inst=%h pc=%h mis=%b expected v=0 inst=00000013 pc=0 mis=0",
               bus.out_valid, bus.out_inst, bus.out_pc, bus.out_misaligned);
    end
    rst = 1'b0;
    n_cmp++;
    if (bus.rom_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rom_addr: got %h expected 00000000", bus.rom_addr);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
      n_err++;
      $display("FAIL reset_perf: got fetched=%0d stall=%0d expected 0/0", perf_fetched, perf_stall);
    end
`endif
  endtask

  task automatic test_free_run();
    exp_q.push_back('{pc: 32'h0, inst: 32'h0, mis: 1'b0});
    exp_q.push_back('{pc: 32'h4, inst: 32'h1, mis: 1'b0});
    exp_q.push_back('{pc: 32'h8, inst: 32'h2, mis: 1'b0});
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL free_run_%0d: got v=%b pc=%h expected v=1 pc=%h", k, bus.out_valid, bus.out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8 || bus.out_inst !== 32'h2 || bus.rom_addr !== 32'hC) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h rom=%h expected v=1 pc=8 inst=2 rom=c",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, bus.rom_addr);
      end
      step();
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if (perf_stall !== 32'd3 || perf_fetched !== 32'd2) begin
      n_err++;
      $display("FAIL stall_perf: got stall=%0d fetched=%0d expected 3/2", perf_stall, perf_fetched);
    end
`endif
    bus.out_ready = 1'b1;
    exp_q.push_back('{pc: 32'hC, inst: 32'h3, mis: 1'b0});
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hC) begin
      n_err++;
      $display("FAIL stall_resume_12: got v=%b pc=%h expected v=1 pc=c", bus.out_valid, bus.out_pc);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_inst !== 32'h4) begin
      n_err++;
      $display("FAIL stall_resume_16: got v=%b pc=%h inst=%h expected v=1 pc=10 inst=4",
               bus.out_valid, bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h10 || bus.rom_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_flush: got v=%b pc=%h rom=%h expected v=0 pc=10 rom=100",
               bus.out_valid, bus.out_pc, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    exp_q.push_back('{pc: 32'h100, inst: 32'h40, mis: 1'b0});
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_target: got v=%b pc=%h expected v=1 pc=100", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_misaligned();
    // Redirect coincides with a handshake of pc 0x100, which still counts as accepted.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h102) begin
      n_err++;
      $display("FAIL mis_flush: got v=%b rom=%h expected v=0 rom=102", bus.out_valid, bus.rom_addr);
    end
    exp_q.push_back('{pc: 32'h102, inst: 32'h13, mis: 1'b1});
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_misaligned !== 1'b1 || bus.out_pc !== 32'h102) begin
      n_err++;
      $display("FAIL mis_output: got v=%b mis=%b pc=%h expected v=1 mis=1 pc=102",
               bus.out_valid, bus.out_misaligned, bus.out_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h102) begin
        n_err++;
        $display("FAIL mis_halt_%0d: got v=%b rom=%h expected v=0 rom=102", i, bus.out_valid, bus.rom_addr);
      end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    exp_q.push_back('{pc: 32'h200, inst: 32'h80, mis: 1'b0});
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL mis_resume: got v=%b pc=%h mis=%b expected v=1 pc=200 mis=0",
               bus.out_valid, bus.out_pc, bus.out_misaligned);
    end
  endtask

  task automatic test_reset_and_wrap();
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h13 || bus.out_pc !== 32'h0 ||
        bus.out_misaligned !== 1'b0 || bus.rom_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_over_redirect: got v=%b inst=%h pc=%h mis=%b rom=%h expected v=0 inst=13 pc=0 mis=0 rom=0",
               bus.out_valid, bus.out_inst, bus.out_pc, bus.out_misaligned, bus.rom_addr);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
      n_err++;
      $display("FAIL rst_perf_clear: got fetched=%0d stall=%0d expected 0/0", perf_fetched, perf_stall);
    end
`endif
    rst = 1'b0;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h3FFF_FFFF, mis: 1'b0});
    step();
    n_cmp++;
    if (bus.out_pc !== 32'hFFFF_FFFC || bus.rom_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_addr: got pc=%h rom=%h expected pc=fffffffc rom=0", bus.out_pc, bus.rom_addr);
    end
    step();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=0",
               bus.out_valid, bus.out_pc, bus.out_inst);
    end
    step();
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_reset_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
